// File: rtl/alu_pkg.sv
// Shared types for the execute stage: ALU operation codes and the
// payload carried by the output main/skid registers.
package alu_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam int DEFAULT_REGW = 5;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_BEQ  = 4'b1000,
    OP_BNE  = 4'b1001,
    OP_PASS = 4'b1010,
    OP_RSVD = 4'b1011,
    OP_SLT  = 4'b1100,
    OP_BGE  = 4'b1101,
    OP_SLTU = 4'b1110,
    OP_BGEU = 4'b1111
  } alu_op_t;

  // One registered instruction result heading to EX/MEM.
  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] result;
    logic                    flag;
    logic [DEFAULT_REGW-1:0] rd;
    logic                    regwrite;
  } ex_payload_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: result and branch/compare flag for every code.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            flag
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  // Decode the operation; defaults keep unused codes at zero.
  always_comb begin
    result = '0;
    flag   = 1'b0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SUB:  result = a - b;
      OP_SRA:  result = $unsigned($signed(a) >>> shamt);
      OP_BEQ:  flag = (a == b);
      OP_BNE:  flag = (a != b);
      OP_SLT:  flag = ($signed(a) < $signed(b));
      OP_BGE:  flag = ($signed(a) >= $signed(b));
      OP_SLTU: flag = (a < b);
      OP_BGEU: flag = (a >= b);
      OP_PASS: begin
        result = b;
        flag   = 1'b1;
      end
      default: begin
        result = '0;
        flag   = 1'b0;
      end
    endcase
    // Compare codes return the compare bit zero-extended as the result.
    if (op == OP_BEQ || op == OP_BNE || op == OP_SLT ||
        op == OP_BGE || op == OP_SLTU || op == OP_BGEU)
      result = {{(XLEN-1){1'b0}}, flag};
  end

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: ALU plus a registered 2-entry (main + skid) output buffer.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is the inverse of the skid-valid flop, so it never
// depends combinationally on out_ready. out_* stay stable while
// out_valid && !out_ready. flush drops everything held and the same-cycle
// input; reset does the same and also zeroes the output data.
module ex_alu_stage
  import alu_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN,
  parameter int REGW = DEFAULT_REGW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_operation,
  input  logic [XLEN-1:0] in_srca,
  input  logic [XLEN-1:0] in_srcb,
  input  logic [REGW-1:0] in_rd,
  input  logic            in_regwrite,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_flag,
  output logic [REGW-1:0] out_rd,
  output logic            out_regwrite
);

  logic            main_valid;
  logic            skid_valid;
  ex_payload_t     main_q;
  ex_payload_t     skid_q;
  ex_payload_t     new_pl;
  logic [XLEN-1:0] alu_result;
  logic            alu_flag;
  logic            accept;
  logic            drain;

  alu_core #(.XLEN(XLEN)) u_alu (
    .op     (alu_op_t'(in_operation)),
    .a      (in_srca),
    .b      (in_srcb),
    .result (alu_result),
    .flag   (alu_flag)
  );

  assign new_pl = '{result: alu_result, flag: alu_flag, rd: in_rd, regwrite: in_regwrite};

  assign in_ready = !skid_valid;
  assign accept   = in_valid && !skid_valid;
  assign drain    = main_valid && out_ready;

  // Main/skid occupancy and data movement.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      // Input is stalled; the skid entry refills main as soon as main drains.
      if (drain) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid || drain) begin
        main_q     <= new_pl;
        main_valid <= 1'b1;
      end else begin
        skid_q     <= new_pl;
        skid_valid <= 1'b1;
      end
    end else if (drain) begin
      main_valid <= 1'b0;
    end
  end

  assign out_valid    = main_valid;
  assign out_result   = main_q.result;
  assign out_flag     = main_q.flag;
  assign out_rd       = main_q.rd;
  assign out_regwrite = main_q.regwrite;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Bench for ex_alu_stage: a 2-deep FIFO model of the output buffer with an
// arithmetic ALU model, checked every cycle, plus directed literal checks.
module tb_ex_alu_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_operation = 4'd0;
  logic [31:0] in_srca = 32'd0;
  logic [31:0] in_srcb = 32'd0;
  logic [4:0]  in_rd = 5'd0;
  logic        in_regwrite = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_flag;
  logic [4:0]  out_rd;
  logic        out_regwrite;

  int n_checks = 0;
  int n_fail = 0;

  // {result[31:0], flag, rd[4:0], regwrite}
  logic [38:0] exp_q[$];
  logic        live = 1'b0;
  logic        zero_exp = 1'b0;

  ex_alu_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_operation(in_operation), .in_srca(in_srca), .in_srcb(in_srcb),
    .in_rd(in_rd), .in_regwrite(in_regwrite),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flag(out_flag),
    .out_rd(out_rd), .out_regwrite(out_regwrite)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference ALU written from the operation table.
  function automatic logic [38:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] rd,
                                            input logic rw);
    logic [31:0] r;
    logic        f;
    int          sa;
    int          sb;
    int          sh;
    sa = a;
    sb = b;
    sh = int'(b & 32'd31);
    r = 32'd0;
    f = 1'b0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = a ^ b;
      4'd4:  r = a << sh;
      4'd5:  r = a >> sh;
      4'd6:  r = a - b;
      4'd7:  r = (a >> sh) | ((a >= 32'h80000000) ? ~(32'hFFFFFFFF >> sh) : 32'd0);
      4'd8:  f = (a == b);
      4'd9:  f = (a != b);
      4'd12: f = (sa < sb);
      4'd13: f = (sa >= sb);
      4'd14: f = (a < b);
      4'd15: f = (a >= b);
      4'd10: begin r = b; f = 1'b1; end
      default: begin r = 32'd0; f = 1'b0; end
    endcase
    if (op == 4'd8 || op == 4'd9 || op >= 4'd12)
      r = f ? 32'd1 : 32'd0;
    return {r, f, rd, rw};
  endfunction

  // Model: a FIFO of capacity 2; input is ready whenever it holds < 2 items.
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      zero_exp <= 1'b1;
      live     <= 1'b1;
    end else begin
      zero_exp <= 1'b0;
      if (flush) begin
        exp_q.delete();
      end else if (in_valid && exp_q.size() < 2) begin
        if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        exp_q.push_back(model_alu(in_operation, in_srca, in_srcb, in_rd, in_regwrite));
      end else if (out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end
    end
  end

  // Scoreboard compare on the falling edge
  always @(negedge clk) begin
    logic [38:0] hd;
    if (live) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
      if (exp_q.size() > 0) begin
        hd = exp_q[0];
        chk("out_result", out_result, hd[38:7]);
        chk("out_flag", {31'd0, out_flag}, {31'd0, hd[6]});
        chk("out_rd", {27'd0, out_rd}, {27'd0, hd[5:1]});
        chk("out_regwrite", {31'd0, out_regwrite}, {31'd0, hd[0]});
      end
      if (zero_exp) begin
        chk("reset_result", out_result, 32'd0);
        chk("reset_meta", {25'd0, out_flag, out_rd, out_regwrite}, 32'd0);
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic rw);
    in_valid     = 1'b1;
    in_operation = op;
    in_srca      = a;
    in_srcb      = b;
    in_rd        = rd;
    in_regwrite  = rw;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic rw);
    drive(op, a, b, rd, rw);
    step();
    in_valid = 1'b0;
  endtask

  // Directed stimulus with literal expectations
  initial begin
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("lit_reset_valid", {31'd0, out_valid}, 32'd0);
    chk("lit_reset_ready", {31'd0, in_ready}, 32'd1);
    chk("lit_reset_result", out_result, 32'd0);

    // ADD / SUB
    out_ready = 1'b1;
    issue(4'b0010, 32'd5, 32'd7, 5'd3, 1'b1);
    chk("lit_add_valid", {31'd0, out_valid}, 32'd1);
    chk("lit_add", out_result, 32'd12);
    chk("lit_add_flag", {31'd0, out_flag}, 32'd0);
    chk("lit_add_rd", {27'd0, out_rd}, 32'd3);
    issue(4'b0110, 32'd5, 32'd7, 5'd4, 1'b1);
    chk("lit_sub", out_result, 32'hFFFFFFFE);

    // Signed / unsigned
    issue(4'b1100, 32'hFFFFFFFF, 32'd1, 5'd5, 1'b1);
    chk("lit_slt", out_result, 32'd1);
    chk("lit_slt_flag", {31'd0, out_flag}, 32'd1);
    issue(4'b1110, 32'hFFFFFFFF, 32'd1, 5'd6, 1'b1);
    chk("lit_sltu", out_result, 32'd0);
    chk("lit_sltu_flag", {31'd0, out_flag}, 32'd0);
    issue(4'b0111, 32'h80000000, 32'd4, 5'd7, 1'b1);
    chk("lit_sra", out_result, 32'hF8000000);
    issue(4'b0100, 32'h00000003, 32'd31, 5'd7, 1'b1);
    chk("lit_sll31", out_result, 32'h80000000);
    issue(4'b0101, 32'h80000000, 32'd33, 5'd7, 1'b0);
    chk("lit_srl_b40", out_result, 32'h40000000);

    // Branch codes
    issue(4'b1000, 32'd9, 32'd9, 5'd0, 1'b0);
    chk("lit_beq_flag", {31'd0, out_flag}, 32'd1);
    issue(4'b1001, 32'd9, 32'd9, 5'd0, 1'b0);
    chk("lit_bne_flag", {31'd0, out_flag}, 32'd0);
    issue(4'b1101, 32'd9, 32'd9, 5'd0, 1'b0);
    chk("lit_bge_flag", {31'd0, out_flag}, 32'd1);
    issue(4'b1111, 32'd1, 32'hFFFFFFFF, 5'd0, 1'b0);
    chk("lit_bgeu_flag", {31'd0, out_flag}, 32'd0);
    issue(4'b1010, 32'd77, 32'h12345000, 5'd8, 1'b1);
    chk("lit_pass", out_result, 32'h12345000);
    chk("lit_pass_flag", {31'd0, out_flag}, 32'd1);
    issue(4'b1011, 32'hFFFF, 32'hFFFF, 5'd8, 1'b1);
    chk("lit_rsvd", out_result, 32'd0);
    chk("lit_rsvd_flag", {31'd0, out_flag}, 32'd0);
    step();
    chk("lit_idle_valid", {31'd0, out_valid}, 32'd0);

    // Back-pressure: main then skid fill, third waits
    out_ready = 1'b0;
    drive(4'b0010, 32'd1, 32'd1, 5'd1, 1'b1);
    step();
    drive(4'b0010, 32'd2, 32'd2, 5'd2, 1'b1);
    step();
    chk("lit_bp_ready_low", {31'd0, in_ready}, 32'd0);
    chk("lit_bp_main", out_result, 32'd2);
    drive(4'b0010, 32'd3, 32'd3, 5'd3, 1'b1);
    step();
    chk("lit_bp_hold", out_result, 32'd2);
    chk("lit_bp_still_low", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    chk("lit_bp_second", out_result, 32'd4);
    chk("lit_bp_ready_back", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("lit_bp_third", out_result, 32'd6);
    step();
    chk("lit_bp_empty", {31'd0, out_valid}, 32'd0);

    // Throughput: back-to-back stream with out_ready high
    for (int i = 0; i < 6; i++) begin
      drive(4'b0011, 32'(i * 17), 32'h0F0F0F0F, 5'(i), 1'(i % 2));
      step();
    end
    in_valid = 1'b0;
    step();

    // Flush with both entries full and a new input present
    out_ready = 1'b0;
    issue(4'b0010, 32'd10, 32'd0, 5'd10, 1'b1);
    issue(4'b0010, 32'd11, 32'd0, 5'd11, 1'b1);
    drive(4'b0010, 32'd12, 32'd0, 5'd12, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("lit_flush_valid", {31'd0, out_valid}, 32'd0);
    chk("lit_flush_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    step();
    step();
    chk("lit_flush_gone", {31'd0, out_valid}, 32'd0);

    // Reset mid-stream with skid full
    out_ready = 1'b0;
    issue(4'b0001, 32'hA0, 32'h0B, 5'd20, 1'b1);
    issue(4'b0001, 32'hC0, 32'h0D, 5'd21, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("lit_mid_reset_valid", {31'd0, out_valid}, 32'd0);
    chk("lit_mid_reset_ready", {31'd0, in_ready}, 32'd1);
    chk("lit_mid_reset_data", {out_result[26:0], out_flag, out_rd[2:0], out_regwrite}, 32'd0);
    chk("lit_mid_reset_rd", {27'd0, out_rd}, 32'd0);
    out_ready = 1'b1;
    issue(4'b0010, 32'd100, 32'd23, 5'd9, 1'b1);
    chk("lit_post_reset_valid", {31'd0, out_valid}, 32'd1);
    chk("lit_post_reset", out_result, 32'd123);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_alu_stage.md
Name: ex_alu_stage

Overview:
- Execute stage of the pipeline. Consumes the 4-bit ALU Operation code produced by the ALU controller, together with operands and destination metadata from ID/EX.
- Computes the ALU result and a branch/compare flag.
- Delivers both through a registered, 2-entry skid-buffered valid/ready output toward EX/MEM.
- Supports back-pressure from downstream and a pipeline flush.

Parameters:
- XLEN, 32, operand/result width.
- REGW, 5, destination register index width.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high
- flush  input  1  kill all held and incoming instructions this cycle
- in_valid  input  1  upstream has an instruction
- in_ready  output  1  stage can accept (registered)
- in_operation  input  4  ALU Operation code from ALU controller
- in_srca  input  XLEN  operand A
- in_srcb  input  XLEN  operand B (reg or immediate)
- in_rd  input  REGW  destination register
- in_regwrite  input  1  writeback enable
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts
- out_result  output  XLEN  ALU result
- out_flag  output  1  branch taken / compare true
- out_rd  output  REGW  registered in_rd
- out_regwrite  output  1  registered in_regwrite

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: out_valid=0, out_result=0, out_flag=0, out_rd=0, out_regwrite=0. in_ready=1 from the first cycle after reset.
- Handshake:
  - Input transfer when in_valid && in_ready at a rising edge.
  - Output transfer when out_valid && out_ready.
  - out_* data are held stable while out_valid && !out_ready.
- Latency: an instruction accepted at edge N appears on out_* after edge N (1 cycle) if the output register was empty or draining.
- Storage: main register (drives out_*) plus one skid register.
  - in_ready = !skid_valid, from a flop; no combinational path from out_ready.
  - Accept while main is empty, or main drains this cycle → result written to main.
  - Accept while main is full and not draining → result written to skid; in_ready drops next cycle.
  - Main drains while skid is full → skid moves to main; skid empties; in_ready=1 next cycle.
  - Simultaneous accept + drain with main full and skid empty → new result goes to main.
  - Throughput: 1 instruction/cycle with out_ready held high.
- Flush (priority over all but reset):
  - main_valid and skid_valid clear at the edge.
  - An input handshake in the same cycle is discarded.
  - Data registers need not clear.
  - out_valid=0 and in_ready=1 after the edge.
- Reset mid-operation: same as flush, plus data outputs go to 0.
- ALU (combinational, computed on in_* before registering). Shifts use srcb[4:0]; signed ops use two's complement.
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 SLL; 0101 SRL; 0110 SUB; 0111 SRA. All with flag=0; ADD/SUB wrap modulo 2^XLEN.
  - 1000 BEQ: a==b.
  - 1001 BNE: a!=b.
  - 1100 SLT/BLT: a<b signed.
  - 1101 BGE: a>=b signed.
  - 1110 SLTU/BLTU: a<b unsigned.
  - 1111 BGEU: a>=b unsigned.
  - For the six compare codes above: result = zero-extended compare bit, flag = compare bit.
  - 1010 JAL/LUI: result = srcb (pass-through), flag=1.
  - 1011 (unused): result=0, flag=0.
- No X propagation: every code defines result and flag.

Decomposition:
- Package alu_pkg:
  - XLEN default.
  - Typedef alu_op_t (4-bit enum, codes above).
  - Typedef ex_payload_t struct {result, flag, rd, regwrite}, used for both main and skid registers.
- Sub-module alu_core: purely combinational; inputs op, a, b; outputs result, flag. The stage instantiates it once.

Test Plan:
- Reset, then single ADD: a=5, b=7, op=0010, out_ready=1 → out_valid one cycle later, result=12, flag=0; SUB of same operands gives 0xFFFFFFFE.
- Signed/unsigned: a=0xFFFFFFFF, b=1. SLT(1100) → result=1, flag=1. SLTU(1110) → result=0, flag=0. SRA(0111) with b=4 on a=0x80000000 → 0xF8000000.
- Back-pressure: stream 3 ADDs back-to-back with out_ready=0 → first held in main, second in skid, in_ready=0 after second, third not accepted. Raise out_ready → all 3 emerge in order, no loss or duplicate.
- Flush with main and skid full and in_valid=1 → next cycle out_valid=0, in_ready=1; the flushed-cycle input never appears.
- Branch codes: a=b=9 → BEQ flag=1, BNE flag=0, BGE flag=1. Op 1010 with b=0x12345000 → result=0x12345000, flag=1. Op 1011 → result=0, flag=0.
- Reset asserted mid-stream with skid full → all outputs 0 next cycle, in_ready=1; first post-reset instruction has 1-cycle latency.
